pu_phase_controller: RTL and testbench
======================================

// Module: pu_phase_controller
// PURPOSE
//  Sequences one position-update phase across all per-cell PositionUpdater instances.
//  Arms them with a common ready and bank select, waits for every cell to finish.
//  Waits for the migration ring to drain, then flips the double buffer.
//  Sits between the top-level timestep sequencer (start/phase_done) and the NCELLS updaters.
// PARAMETERS
//  NCELLS        27    number of cell updaters (UNIVERSE^3)
//  ARM_CYCLES    2     cycles ready is held low before RUN (updaters sample on negedge)
//  QUIET_CYCLES  4     consecutive ring-empty cycles required to declare drain complete
//  TIMEOUT       65535 max cycles in RUN+DRAIN before error
// PORTS
//  clk            in   1       system clock, all state on posedge
//  rst            in   1       synchronous, active-high reset
//  start          in   1       pulse: begin a phase; accepted only in IDLE
//  pu_done        in   NCELLS  per-updater done level
//  ring_valid     in   NCELLS  per-node ring slot occupied (nodeCOut[32]==0)
//  ready          out  1       broadcast ready to all updaters
//  double_buffer  out  2       bank select to updaters; one-hot 01=bank0 read, 10=bank1 read
//  busy           out  1       high in any state other than IDLE/ERROR
//  phase_done     out  1       1-cycle pulse when a phase completes
//  timeout_err    out  1       sticky error flag
//  phase_cycles   out  32      cycles from RUN entry to SWAP, latched at SWAP
// BEHAVIOUR
//  Reset: state=IDLE, ready=0, double_buffer=2'b01, busy=0, phase_done=0, timeout_err=0, phase_cycles=0;
//   all counters 0. rst mid-phase aborts to this state immediately; no bank flip occurs.
//  FSM states IDLE, ARM, RUN, DRAIN, SWAP, ERROR:
//   IDLE : ready=0. start=1 -> ARM, clear timeout_err, arm_cnt=0.
//   ARM  : ready=0 (updaters reload base addr 0/DBSIZE from double_buffer[0], clear done).
//          After ARM_CYCLES cycles -> RUN, run_cnt=0, tmo_cnt=0.
//   RUN  : ready=1. pu_done ignored for first 2 RUN cycles (guard vs stale done).
//          After the guard, &pu_done=1 -> DRAIN, quiet_cnt=0.
//   DRAIN: ready=1. Each cycle: |ring_valid=1 -> quiet_cnt=0, else quiet_cnt++.
//          quiet_cnt reaches QUIET_CYCLES -> SWAP.
//          &pu_done dropping to 0 (cell accepted a migrant) -> back to RUN, guard not re-applied.
//   SWAP : single cycle; ready=0 next; double_buffer <= ~double_buffer (01<->10);
//          phase_done=1 for this cycle only; phase_cycles <= run_cnt; -> IDLE.
//   ERROR: ready=0, timeout_err=1; double_buffer unchanged.
//          start -> ARM (clears timeout_err, same bank retried).
//  Timeout: tmo_cnt increments in RUN and DRAIN; tmo_cnt==TIMEOUT-1 while still in RUN/DRAIN -> ERROR.
//   Timeout takes priority over the SWAP transition in the same cycle.
//  run_cnt: 32-bit, increments every cycle in RUN and DRAIN, saturates at 2^32-1.
//  start while busy is ignored (no queueing). start in SWAP cycle is ignored.
//  Outputs registered; ready and double_buffer change only on posedge clk.
//  double_buffer never takes values 00/11.
// STRUCTURE
//  Shared package md_pkg: state encoding localparams, BANK0=2'b01, BANK1=2'b10, NULL33={1'b1,32'b0}.
//  One natural sub-module: pu_quiet_detector (ring_valid OR-reduce + QUIET_CYCLES counter, clear input).
//  Everything else flat in this module.
// TESTING
//  rst, then start; all pu_done=1 at RUN cycle 3, ring_valid=0
//   -> ready high from RUN entry; phase_done at RUN+2+1+4+1; double_buffer 01->10.
//  Second start -> double_buffer 10->01; phase_cycles matches cycle count from RUN entry.
//  pu_done=all 1 already before start -> RUN holds 2 guard cycles, no early DRAIN.
//  DRAIN: ring_valid[5] toggles 1 every 3rd cycle for 20 cycles -> no SWAP until 4 consecutive empty cycles.
//  TIMEOUT=16, pu_done[0] held 0 -> ERROR at tmo_cnt 15; timeout_err=1; ready=0; bank unchanged.
//   start -> ARM, timeout_err cleared.
//  rst asserted in DRAIN -> next cycle IDLE, ready=0, double_buffer=01, no phase_done pulse.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the position-update phase controller.
package md_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_SWAP  = 3'd4,
    ST_ERROR = 3'd5
  } pu_state_t;

  // One-hot bank select: bit0 set means updaters read bank0.
  localparam logic [1:0]  BANK0 = 2'b01;
  localparam logic [1:0]  BANK1 = 2'b10;

  // Empty ring slot marker (bit 32 set, payload zero).
  localparam logic [32:0] NULL33 = {1'b1, 32'b0};

  // RUN cycles during which pu_done is ignored, so stale done levels from
  // the previous phase cannot short-circuit the new one.
  localparam int GUARD_CYCLES = 2;

endpackage

// File: rtl/pu_quiet_detector.sv
// Detects a run of QUIET_CYCLES consecutive cycles with an empty migration ring.
// quiet is asserted combinationally on the cycle that completes the run.
module pu_quiet_detector #(
  parameter int NCELLS       = 27,
  parameter int QUIET_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [NCELLS-1:0] ring_valid,
  output logic              quiet
);

  localparam int QW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
  localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYCLES - 1);

  logic          ring_busy;
  logic [QW-1:0] quiet_cnt_q;
  logic [QW-1:0] quiet_cnt_d;

  assign ring_busy = |ring_valid;

  // Count consecutive empty cycles; any occupied slot restarts the run.
  always_comb begin
    quiet_cnt_d = quiet_cnt_q;
    if (clear || ring_busy) begin
      quiet_cnt_d = '0;
    end else if (quiet_cnt_q != QUIET_LAST) begin
      quiet_cnt_d = quiet_cnt_q + QW'(1);
    end
  end

  // Quiet-run counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      quiet_cnt_q <= '0;
    end else begin
      quiet_cnt_q <= quiet_cnt_d;
    end
  end

  assign quiet = !clear && !ring_busy && (quiet_cnt_q == QUIET_LAST);

endmodule

// File: rtl/pu_phase_controller.sv
// Sequences one position-update phase across all cell updaters and flips
// the double buffer once every cell is done and the migration ring is quiet.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start, ready low
// ARM      | ready low so updaters reload base address and clear done
// RUN      | ready high, waiting for all cells done (after guard cycles)
// DRAIN    | ready high, waiting for ring to stay empty QUIET_CYCLES
// SWAP     | one cycle: flip bank, pulse phase_done, latch phase_cycles
// ERROR    | timed out, ready low, sticky timeout_err, bank unchanged
module pu_phase_controller
  import md_pkg::*;
#(
  parameter int NCELLS       = 27,
  parameter int ARM_CYCLES   = 2,
  parameter int QUIET_CYCLES = 4,
  parameter int TIMEOUT      = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NCELLS-1:0] pu_done,
  input  logic [NCELLS-1:0] ring_valid,
  output logic              ready,
  output logic [1:0]        double_buffer,
  output logic              busy,
  output logic              phase_done,
  output logic              timeout_err,
  output logic [31:0]       phase_cycles
);

  localparam int AW = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW-1:0] ARM_LOAD = AW'(ARM_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

  pu_state_t   state_q, state_d;
  logic [AW-1:0] arm_cnt_q, arm_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [31:0] run_cnt_q, run_cnt_d;
  logic [31:0] run_cnt_inc;
  logic [31:0] phase_cycles_q, phase_cycles_d;
  logic [1:0]  double_buffer_q, double_buffer_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        phase_done_q, phase_done_d;
  logic        timeout_err_q, timeout_err_d;
  logic        all_done;
  logic        guard_over;
  logic        quiet;

  assign all_done    = &pu_done;
  assign guard_over  = (run_cnt_q >= 32'(GUARD_CYCLES));
  assign run_cnt_inc = (run_cnt_q != '1) ? run_cnt_q + 32'd1 : run_cnt_q;

  pu_quiet_detector #(
    .NCELLS       (NCELLS),
    .QUIET_CYCLES (QUIET_CYCLES)
  ) u_quiet (
    .clk        (clk),
    .rst        (rst),
    .clear      (state_q != ST_DRAIN),
    .ring_valid (ring_valid),
    .quiet      (quiet)
  );

  // Next-state, counters and registered-output next values.
  always_comb begin
    state_d         = state_q;
    arm_cnt_d       = arm_cnt_q;
    tmo_cnt_d       = tmo_cnt_q;
    run_cnt_d       = run_cnt_q;
    phase_cycles_d  = phase_cycles_q;
    double_buffer_d = double_buffer_q;

    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (start) begin
          state_d   = ST_ARM;
          arm_cnt_d = ARM_LOAD;
        end
      end
      ST_ARM: begin
        if (arm_cnt_q == '0) begin
          state_d   = ST_RUN;
          run_cnt_d = '0;
          tmo_cnt_d = TMO_LOAD;
        end else begin
          arm_cnt_d = arm_cnt_q - AW'(1);
        end
      end
      ST_RUN: begin
        run_cnt_d = run_cnt_inc;
        if (tmo_cnt_q != '0) tmo_cnt_d = tmo_cnt_q - TW'(1);
        if (tmo_cnt_q == '0)            state_d = ST_ERROR;
        else if (guard_over && all_done) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        run_cnt_d = run_cnt_inc;
        if (tmo_cnt_q != '0) tmo_cnt_d = tmo_cnt_q - TW'(1);
        // A cell dropping done means it took a migrant and must finish again.
        if (tmo_cnt_q == '0)  state_d = ST_ERROR;
        else if (!all_done)   state_d = ST_RUN;
        else if (quiet)       state_d = ST_SWAP;
      end
      ST_SWAP: begin
        state_d         = ST_IDLE;
        double_buffer_d = ~double_buffer_q;
        phase_cycles_d  = run_cnt_q;
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d       = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    busy_d        = (state_d != ST_IDLE) && (state_d != ST_ERROR);
    phase_done_d  = (state_d == ST_SWAP);
    timeout_err_d = (state_d == ST_ERROR);
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      arm_cnt_q       <= '0;
      tmo_cnt_q       <= '0;
      run_cnt_q       <= '0;
      phase_cycles_q  <= '0;
      double_buffer_q <= BANK0;
      ready_q         <= 1'b0;
      busy_q          <= 1'b0;
      phase_done_q    <= 1'b0;
      timeout_err_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      arm_cnt_q       <= arm_cnt_d;
      tmo_cnt_q       <= tmo_cnt_d;
      run_cnt_q       <= run_cnt_d;
      phase_cycles_q  <= phase_cycles_d;
      double_buffer_q <= double_buffer_d;
      ready_q         <= ready_d;
      busy_q          <= busy_d;
      phase_done_q    <= phase_done_d;
      timeout_err_q   <= timeout_err_d;
    end
  end

  assign ready         = ready_q;
  assign double_buffer = double_buffer_q;
  assign busy          = busy_q;
  assign phase_done    = phase_done_q;
  assign timeout_err   = timeout_err_q;
  assign phase_cycles  = phase_cycles_q;

endmodule

// File: tb/tb_pu_phase_controller.sv
// Directed bench for pu_phase_controller: default instance for phase flow,
// a TIMEOUT=16 instance for the error path.
module tb_pu_phase_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [26:0] pu_done;
  logic [26:0] ring_valid;

  logic        ready, busy, phase_done, timeout_err;
  logic [1:0]  double_buffer;
  logic [31:0] phase_cycles;

  logic        t_ready, t_busy, t_phase_done, t_timeout_err;
  logic [1:0]  t_double_buffer;
  logic [31:0] t_phase_cycles;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [1:0]  exp_bank;

  always #5 clk = ~clk;

  pu_phase_controller dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .pu_done       (pu_done),
    .ring_valid    (ring_valid),
    .ready         (ready),
    .double_buffer (double_buffer),
    .busy          (busy),
    .phase_done    (phase_done),
    .timeout_err   (timeout_err),
    .phase_cycles  (phase_cycles)
  );

  pu_phase_controller #(.TIMEOUT(16)) dut_t (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .pu_done       (pu_done),
    .ring_valid    (ring_valid),
    .ready         (t_ready),
    .double_buffer (t_double_buffer),
    .busy          (t_busy),
    .phase_done    (t_phase_done),
    .timeout_err   (t_timeout_err),
    .phase_cycles  (t_phase_cycles)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full phase on the default instance. c counts cycles from RUN entry;
  // exp_len is the RUN-relative cycle index of the SWAP cycle.
  task automatic run_phase(input string tag, input int done_at, input int drop_at,
                           input bit toggle, input bit start_busy, input int exp_len);
    int k;
    int c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy_arm"}, 32'(busy), 32'd1);
    k = 0;
    while (!ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    check({tag, " arm_lat"}, 32'(k), 32'd2);
    c = 0;
    while (!phase_done && c < 60) begin
      if (c >= done_at) pu_done = '1;
      if (c == drop_at) pu_done[3] = 1'b0;
      ring_valid = (toggle && c >= 3 && c <= 22 && ((c - 3) % 3) == 0) ? 27'(1 << 5) : '0;
      start = start_busy && (c == 1);
      @(negedge clk);
      c++;
    end
    check({tag, " len"}, 32'(c), 32'(exp_len));
    check({tag, " rdy_swap"}, 32'(ready), 32'd0);
    check({tag, " bank_swap"}, 32'(double_buffer), 32'(exp_bank));
    ring_valid = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_bank = ~exp_bank;
    check({tag, " pd_clear"}, 32'(phase_done), 32'd0);
    check({tag, " busy_idle"}, 32'(busy), 32'd0);
    check({tag, " bank_flip"}, 32'(double_buffer), 32'(exp_bank));
    check({tag, " cycles"}, phase_cycles, 32'(exp_len));
    pu_done = '0;
    @(negedge clk);
  endtask

  initial begin
    int k;
    int c;
    int pd_seen;
    rst        = 1'b1;
    start      = 1'b0;
    pu_done    = '0;
    ring_valid = '0;
    exp_bank   = 2'b01;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst ready", 32'(ready), 32'd0);
    check("rst bank", 32'(double_buffer), 32'h1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst phase_done", 32'(phase_done), 32'd0);
    check("rst timeout_err", 32'(timeout_err), 32'd0);
    check("rst phase_cycles", phase_cycles, 32'd0);

    run_phase("A", 2, -1, 1'b0, 1'b0, 7);
    run_phase("B", 4, -1, 1'b0, 1'b1, 9);
    pu_done = '1;
    run_phase("C", 0, -1, 1'b0, 1'b0, 7);
    run_phase("D", 2, -1, 1'b1, 1'b0, 26);
    run_phase("E", 2, 4, 1'b0, 1'b0, 10);

    // Reset while draining: abort, bank back to 01, no phase_done.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("rstd arm_lat", 32'(k), 32'd2);
    for (int i = 0; i < 5; i++) begin
      if (i >= 2) pu_done = '1;
      @(negedge clk);
    end
    check("rstd ready_pre", 32'(ready), 32'd1);
    check("rstd bank_pre", 32'(double_buffer), 32'h2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pu_done = '0;
    check("rstd ready", 32'(ready), 32'd0);
    check("rstd busy", 32'(busy), 32'd0);
    check("rstd bank", 32'(double_buffer), 32'h1);
    check("rstd cycles", phase_cycles, 32'd0);
    pd_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (phase_done) pd_seen++;
      @(negedge clk);
    end
    check("rstd no_pd", 32'(pd_seen), 32'd0);

    // Timeout path on the TIMEOUT=16 instance.
    pu_done = 27'h7FF_FFFE;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!t_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("tmo arm_lat", 32'(k), 32'd2);
    c = 0;
    while (!t_timeout_err && c < 40) begin
      @(negedge clk);
      c++;
    end
    check("tmo len", 32'(c), 32'd16);
    check("tmo ready", 32'(t_ready), 32'd0);
    check("tmo busy", 32'(t_busy), 32'd0);
    check("tmo bank", 32'(t_double_buffer), 32'h1);
    check("tmo pd", 32'(t_phase_done), 32'd0);
    @(negedge clk);
    check("tmo sticky", 32'(t_timeout_err), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("tmo err_clr", 32'(t_timeout_err), 32'd0);
    check("tmo busy_arm", 32'(t_busy), 32'd1);
    check("tmo bank_keep", 32'(t_double_buffer), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
